// File: rtl/core_dispatch_issue.sv
// Dual-issue dispatch sequencer: holds one decoded pair and issues it as a pair, or split over two cycles.
// Optional statistics counters are enabled with `define CORE_DISPATCH_STATS_EN.

package core_uarch_pkg;

    typedef struct packed {
        logic       execute;
        logic       branch;
        logic       mul;
        logic       ldst;
    } insn_ctrl_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic       writeback;
        logic [4:0] rd;
        logic       uses_ra;
        logic [4:0] ra;
        logic       uses_rb;
        logic [4:0] rb;
    } insn_data_t;

    typedef struct packed {
        insn_ctrl_t ctrl;
        insn_data_t data;
    } insn_decode;

endpackage

module core_dispatch_issue
    import core_uarch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       in_b_valid,
    input  insn_decode in_a,
    input  insn_decode in_b,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       issue_a_valid,
    output insn_decode issue_a,
    output logic       issue_b_valid,
    output insn_decode issue_b,
    output logic       split
`ifdef CORE_DISPATCH_STATS_EN
    ,
    output logic [31:0] stat_split_count,
    output logic [31:0] stat_stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_PAIR   = 2'd1,
        ST_SOLO_B = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    insn_decode r_held_a;
    insn_decode r_held_b;
    logic       r_held_b_v;

    logic w_raw;
    logic w_struct;
    logic w_conflict;
    logic w_in_pair;
    logic w_in_solo;
    logic w_drained;
    logic w_to_solo;
    logic w_load;

    // B depends on A, or both need the same single-instance unit; an A branch
    // always issues alone so B never enters execute down a mispredicted path.
    assign w_raw = r_held_a.data.writeback &&
                   ((r_held_b.data.uses_ra && (r_held_b.data.ra == r_held_a.data.rd)) ||
                    (r_held_b.data.uses_rb && (r_held_b.data.rb == r_held_a.data.rd)));
    assign w_struct = r_held_a.ctrl.branch ||
                      (r_held_a.ctrl.mul  && r_held_b.ctrl.mul) ||
                      (r_held_a.ctrl.ldst && r_held_b.ctrl.ldst);
    assign w_conflict = r_held_b_v && r_held_a.ctrl.execute && r_held_b.ctrl.execute &&
                        (w_raw || w_struct);

    assign w_in_pair = (r_state == ST_PAIR);
    assign w_in_solo = (r_state == ST_SOLO_B);
    assign w_drained = out_ready && ((w_in_pair && !w_conflict) || w_in_solo);
    assign w_to_solo = out_ready && w_in_pair && w_conflict;

    // Accepting while draining gives back-to-back pairs with no bubble.
    assign in_ready = (r_state == ST_EMPTY) || w_drained;
    assign w_load   = in_valid && in_ready && !flush;

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else if (w_load) begin
            w_state_next = ST_PAIR;
        end else if (w_to_solo) begin
            w_state_next = ST_SOLO_B;
        end else if (w_drained) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held_a   <= '0;
            r_held_b   <= '0;
            r_held_b_v <= 1'b0;
        end else if (flush) begin
            r_held_b_v <= 1'b0;
        end else if (w_load) begin
            r_held_a   <= in_a;
            r_held_b   <= in_b;
            r_held_b_v <= in_b_valid;
        end
    end

    // Issue lanes depend only on held registers and state.
    always_comb begin
        issue_a_valid = w_in_pair || w_in_solo;
        issue_a       = w_in_solo ? r_held_b : r_held_a;
        issue_b_valid = w_in_pair && r_held_b_v && !w_conflict;
        issue_b       = r_held_b;
        split         = (w_in_pair && w_conflict) || w_in_solo;
    end

`ifdef CORE_DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_split_count <= '0;
            stat_stall_count <= '0;
        end else begin
            if (w_to_solo && !flush) begin
                stat_split_count <= stat_split_count + 32'd1;
            end
            if (issue_a_valid && !out_ready) begin
                stat_stall_count <= stat_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_dispatch_issue.sv
// Scoreboard bench for core_dispatch_issue: expected issues are queued at acceptance and checked at issue.
module tb_core_dispatch_issue;
    import core_uarch_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_b_valid;
    insn_decode in_a;
    insn_decode in_b;
    logic       in_ready;
    logic       out_ready;
    logic       issue_a_valid;
    insn_decode issue_a;
    logic       issue_b_valid;
    insn_decode issue_b;
    logic       split;
`ifdef CORE_DISPATCH_STATS_EN
    logic [31:0] stat_split_count;
    logic [31:0] stat_stall_count;
    logic [31:0] stall0;
    logic [31:0] split0;
`endif

    core_dispatch_issue dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_b_valid    (in_b_valid),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_ready      (in_ready),
        .out_ready     (out_ready),
        .issue_a_valid (issue_a_valid),
        .issue_a       (issue_a),
        .issue_b_valid (issue_b_valid),
        .issue_b       (issue_b),
        .split         (split)
`ifdef CORE_DISPATCH_STATS_EN
        ,
        .stat_split_count (stat_split_count),
        .stat_stall_count (stat_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        insn_decode a;
        logic       bv;
        insn_decode b;
        logic       split;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic insn_decode mk(input logic [7:0] op, input logic wb, input logic [4:0] rd,
                                      input logic ura, input logic [4:0] ra,
                                      input logic urb, input logic [4:0] rb,
                                      input logic br, input logic mul, input logic ldst,
                                      input logic exe);
        insn_decode x;
        x = '0;
        x.data.opcode    = op;
        x.data.writeback = wb;
        x.data.rd        = rd;
        x.data.uses_ra   = ura;
        x.data.ra        = ra;
        x.data.uses_rb   = urb;
        x.data.rb        = rb;
        x.ctrl.branch    = br;
        x.ctrl.mul       = mul;
        x.ctrl.ldst      = ldst;
        x.ctrl.execute   = exe;
        return x;
    endfunction

    // Reference pairing rule.
    function automatic logic must_split(input insn_decode a, input insn_decode b, input logic bv);
        logic dep;
        if (!bv || !a.ctrl.execute || !b.ctrl.execute) return 1'b0;
        dep = a.data.writeback &&
              ((b.data.uses_ra && b.data.ra == a.data.rd) || (b.data.uses_rb && b.data.rb == a.data.rd));
        return dep || a.ctrl.branch || (a.ctrl.mul && b.ctrl.mul) || (a.ctrl.ldst && b.ctrl.ldst);
    endfunction

    task automatic push_expected(input insn_decode a, input insn_decode b, input logic bv);
        exp_t e;
        if (must_split(a, b, bv)) begin
            e.a = a; e.bv = 1'b0; e.b = '0; e.split = 1'b1;
            exp_q.push_back(e);
            e.a = b;
            exp_q.push_back(e);
        end else begin
            e.a = a; e.bv = bv; e.b = b; e.split = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Returns at posedge+1 of the first cycle the pair is held.
    task automatic offer(input insn_decode a, input insn_decode b, input logic bv, output int waits);
        logic got;
        got        = 1'b0;
        waits      = 0;
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        in_b_valid = bv;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waits++;
            if (in_ready) begin
                push_expected(a, b, bv);
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    // Scoreboard: one completed issue per cycle with a valid lane and out_ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && out_ready && issue_a_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                $display("[%0t] issue A op=%0h B%s op=%0h split=%0b", $time,
                         issue_a.data.opcode, issue_b_valid ? "" : "(none)",
                         issue_b.data.opcode, split);
                check("lane_a", 64'(issue_a), 64'(e.a));
                check("lane_b_valid", 64'(issue_b_valid), 64'(e.bv));
                if (e.bv) check("lane_b", 64'(issue_b), 64'(e.b));
                check("split", 64'(split), 64'(e.split));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        insn_decode a1, b1, a2, b2, raw_a, raw_b, ia, ib, snap;
        insn_decode sa[3];
        insn_decode sb[3];
        int waits;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_b_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;

        a1    = mk(8'h11, 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 1);
        b1    = mk(8'h12, 1, 5'd4, 1, 5'd5, 1, 5'd6, 0, 0, 0, 1);
        a2    = mk(8'h21, 1, 5'd7, 1, 5'd8, 0, 5'd0, 0, 0, 0, 1);
        b2    = mk(8'h22, 1, 5'd9, 1, 5'd10, 0, 5'd0, 0, 0, 0, 1);
        raw_a = mk(8'h31, 1, 5'd3, 1, 5'd1, 0, 5'd0, 0, 0, 0, 1);
        raw_b = mk(8'h32, 1, 5'd8, 1, 5'd3, 0, 5'd0, 0, 0, 0, 1);
        sa[0] = mk(8'h41, 1, 5'd11, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
        sb[0] = mk(8'h42, 1, 5'd12, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
        sa[1] = mk(8'h51, 1, 5'd13, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
        sb[1] = mk(8'h52, 1, 5'd14, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
        sa[2] = mk(8'h61, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 1);
        sb[2] = mk(8'h62, 1, 5'd15, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1);

        // Reset state
        @(negedge clk);
        check("rst_a_valid", 64'(issue_a_valid), 64'd0);
        check("rst_b_valid", 64'(issue_b_valid), 64'd0);
        check("rst_split", 64'(split), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Independent pairs, back to back
        offer(a1, b1, 1'b1, waits);
        offer(a2, b2, 1'b1, waits);
        check("b2b_accept_waits", 64'(waits), 64'd1);
        @(negedge clk);
        check("b2b_dual_b_valid", 64'(issue_b_valid), 64'd1);
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        wait_drain();

        // RAW dependency split
        offer(raw_a, raw_b, 1'b1, waits);
        @(negedge clk);
        check("raw_c1_split", 64'(split), 64'd1);
        check("raw_c1_b_valid", 64'(issue_b_valid), 64'd0);
        check("raw_c1_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("raw_c2_lane_a", 64'(issue_a), 64'(raw_b));
        check("raw_c2_in_ready", 64'(in_ready), 64'd1);
        wait_drain();

        // Structural conflicts, then the same pairs with B not executing
        for (int k = 0; k < 3; k++) begin
            offer(sa[k], sb[k], 1'b1, waits);
            wait_drain();
            ib = sb[k];
            ib.ctrl.execute = 1'b0;
            offer(sa[k], ib, 1'b1, waits);
            wait_drain();
        end

        // Back-pressure on a split pair
`ifdef CORE_DISPATCH_STATS_EN
        stall0 = stat_stall_count;
        split0 = stat_split_count;
`endif
        out_ready = 1'b0;
        offer(raw_a, raw_b, 1'b1, waits);
        @(negedge clk);
        snap = issue_a;
        check("bp_lane_a0", 64'(issue_a), 64'(raw_a));
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_a", 64'(issue_a), 64'(snap));
            check("bp_hold_valid", 64'(issue_a_valid), 64'd1);
            check("bp_hold_split", 64'(split), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
`ifdef CORE_DISPATCH_STATS_EN
        check("stat_stall", 64'(stat_stall_count - stall0), 64'd5);
`endif
        out_ready = 1'b1;
        wait_drain();
`ifdef CORE_DISPATCH_STATS_EN
        check("stat_split", 64'(stat_split_count - split0), 64'd1);
`endif

        // Flush while issuing the younger half
        offer(raw_a, raw_b, 1'b1, waits);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_a = a1; in_b = b1; in_b_valid = 1'b1;
        @(negedge clk);
        check("flush_solo_split", 64'(split), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_a_valid", 64'(issue_a_valid), 64'd0);
        check("flush_b_valid", 64'(issue_b_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a held pair
        out_ready = 1'b0;
        offer(a2, b2, 1'b1, waits);
        #1 rst = 1'b1;
        #1;
        check("arst_a_valid", 64'(issue_a_valid), 64'd0);
        check("arst_b_valid", 64'(issue_b_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        out_ready = 1'b1;
        #1 rst = 1'b0;

        // Pair with slot B empty
        ia = mk(8'h71, 1, 5'd3, 0, 5'd0, 0, 5'd0, 1, 0, 0, 1);
        offer(ia, raw_b, 1'b0, waits);
        @(negedge clk);
        check("solo_b_valid", 64'(issue_b_valid), 64'd0);
        check("solo_split", 64'(split), 64'd0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_dispatch_issue.md
Name: core_dispatch_issue

Overview:
- Dual-issue dispatch sequencer between decode and the execution units.
- Holds one decoded instruction pair (A older, B younger) and decides each cycle whether to issue it as a pair or split it over two cycles, based on dependency and structural-conflict rules.
- Issues over two lanes to the execute stage under a valid/ready handshake, with a pipeline flush.

Parameters:
- None. Payload type is insn_decode from core/uarch.sv.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- flush  input  1  discard held pair, synchronous
- in_valid  input  1  decode offers a pair
- in_b_valid  input  1  slot B of offered pair is populated
- in_a  input  insn_decode  older instruction
- in_b  input  insn_decode  younger instruction
- in_ready  output  1  pair accepted this cycle when in_valid=1
- out_ready  input  1  execute stage accepts this cycle's issue
- issue_a_valid  output  1  lane A carries an instruction
- issue_a  output  insn_decode  lane A payload
- issue_b_valid  output  1  lane B carries an instruction
- issue_b  output  insn_decode  lane B payload
- split  output  1  current held pair is split (debug)

Behaviour:
- Registers:
  - held_a, held_b (insn_decode)
  - held_b_v (1 bit)
  - state in {EMPTY, PAIR, SOLO_B}
- Reset (async, rst=1):
  - state=EMPTY, held_b_v=0, payload registers cleared.
  - All valid outputs 0, split=0, in_ready=1.
- Conflict rule, evaluated combinationally on held_a/held_b. conflict=1 if any of:
  - held_a.data.writeback && ((held_b.data.uses_ra && held_b.data.ra==held_a.data.rd) || (held_b.data.uses_rb && held_b.data.rb==held_a.data.rd))
  - held_a.ctrl.branch
  - held_a.ctrl.mul && held_b.ctrl.mul
  - held_a.ctrl.ldst && held_b.ctrl.ldst
  - Override: conflict forced to 0 if !held_a.ctrl.execute or !held_b.ctrl.execute.
  - conflict is ignored when held_b_v=0.
- Outputs by state:
  - EMPTY: no issue.
  - PAIR, held_b_v=0: lane A = held_a; lane B invalid.
  - PAIR, held_b_v=1, conflict=0: lane A = held_a, lane B = held_b, dual issue.
  - PAIR, held_b_v=1, conflict=1: lane A = held_a only; split=1.
  - SOLO_B: lane A = held_b, lane B invalid; split=1.
  - Outputs are driven from registers/state only; there is no combinational path from in_* to issue_*.
- Issue completes when out_ready=1 and a lane is valid. Payload and valids must stay stable while out_ready=0.
- Transitions (out_ready=1):
  - PAIR, split → SOLO_B.
  - PAIR, not split → drained.
  - SOLO_B → drained.
- in_ready = (state==EMPTY) || drained-this-cycle. This permits back-to-back pairs with zero bubble.
- Load: if in_valid && in_ready, capture in_a, in_b, in_b_valid and go to PAIR; otherwise go EMPTY when drained.
- Latency: one cycle from acceptance to first issue. A split pair takes 2 issue cycles minimum.
- Flush:
  - Next state EMPTY, held_b_v=0.
  - Overrides out_ready and in_valid in the same cycle; input is not accepted.
  - In the flush cycle in_ready may be 1, but the pair is dropped. Decode must treat flush as discarding its offer.
- Back-pressure: out_ready=0 holds state indefinitely; in_ready=0 unless EMPTY.

Optional Feature:
- Macro: CORE_DISPATCH_STATS_EN.
- When defined, adds two outputs:
  - stat_split_count [31:0]: +1 on each PAIR→SOLO_B transition.
  - stat_stall_count [31:0]: +1 on each cycle with a valid lane and out_ready=0.
- Both counters wrap modulo 2^32 and clear on rst only; flush does not clear them.
- When undefined, the ports and logic are absent; core behaviour is identical.

Test Plan:
- Independent pair: A=add r1←r2,r3; B=add r4←r5,r6; out_ready=1 → next cycle both lanes valid, split=0; in_ready=1 same cycle; next pair issues the following cycle.
- RAW split: A writes r3; B reads ra=r3 → cycle1 lane A=A only, split=1; cycle2 lane A=B; in_ready=1 only in cycle2.
- Structural: both mul, then both ldst, then A branch → each splits into two issue cycles. Same pairs with B.ctrl.execute=0 → dual issue, no split.
- Back-pressure: RAW-split pair held with out_ready=0 for 5 cycles → outputs stable, state unchanged, in_ready=0. With stats enabled, stat_stall_count=5.
- Flush in SOLO_B with in_valid=1 → next cycle all lanes invalid, offered pair not captured, in_ready=1.
- Async reset asserted mid-PAIR between clock edges → valids drop immediately; after release, first pair issues normally. in_b_valid=0 pair → lane B invalid, no split.
